// File: rtl/timer_tick_master.sv
// timer_tick_master
//   Avalon-MM master that programs an interval-timer slave, services its
//   timeout interrupts and stops it on request.
//   Ports:
//     clk, reset_n (async, active-low)
//     start / stop         : one-cycle control requests
//     period, continuous   : timer configuration, captured on accepted start
//     timer_irq            : timeout interrupt from the timer slave
//     avm_*                : master port (3-bit word address, 16-bit data)
//     busy                 : FSM not idle
//     tick, tick_count     : per-timeout pulse and serviced-timeout count
//   Optional feature (macro TIMER_TICK_MASTER_SNAP_EN):
//     snap_req -> snapshot[31:0] / snap_valid, reading the timer snap registers.
module timer_tick_master #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       period,
  input  logic              continuous,
  input  logic              timer_irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count
`ifdef TIMER_TICK_MASTER_SNAP_EN
  ,
  input  logic              snap_req,
  output logic [31:0]       snapshot,
  output logic              snap_valid
`endif
);

`ifdef TIMER_TICK_MASTER_SNAP_EN
  typedef enum logic [3:0] {
    IDLE, WR_PERL, WR_PERH, WR_CTRL, RUN, CLR_STS, WR_STOP,
    SNAP_WR, SNAP_RDL, SNAP_RDH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WR_PERL, WR_PERH, WR_CTRL, RUN, CLR_STS, WR_STOP
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                cont_q, cont_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic                stop_pend_q, stop_pend_d;
  // Marks the CLR_STS that follows WR_STOP: clears status but is not a tick.
  logic                stop_seq_q, stop_seq_d;

`ifdef TIMER_TICK_MASTER_SNAP_EN
  logic [31:0]         snapshot_q, snapshot_d;
  logic                snap_hi_q, snap_hi_d;
  logic                snap_valid_q, snap_valid_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      tick_count_q <= '0;
      stop_pend_q  <= 1'b0;
      stop_seq_q   <= 1'b0;
`ifdef TIMER_TICK_MASTER_SNAP_EN
      snapshot_q   <= '0;
      snap_hi_q    <= 1'b0;
      snap_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      tick_count_q <= tick_count_d;
      stop_pend_q  <= stop_pend_d;
      stop_seq_q   <= stop_seq_d;
`ifdef TIMER_TICK_MASTER_SNAP_EN
      snapshot_q   <= snapshot_d;
      snap_hi_q    <= snap_hi_d;
      snap_valid_q <= snap_valid_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WR_PERL;
      WR_PERL: state_d = WR_PERH;
      WR_PERH: state_d = WR_CTRL;
      WR_CTRL: state_d = RUN;
      RUN: begin
        // stop beats irq; irq beats snapshot
        if (stop || stop_pend_q) state_d = WR_STOP;
        else if (timer_irq)      state_d = CLR_STS;
`ifdef TIMER_TICK_MASTER_SNAP_EN
        else if (snap_req)       state_d = SNAP_WR;
`endif
      end
      CLR_STS: state_d = (!stop_seq_q && cont_q) ? RUN : IDLE;
      WR_STOP: state_d = CLR_STS;
`ifdef TIMER_TICK_MASTER_SNAP_EN
      SNAP_WR:  state_d = SNAP_RDL;
      SNAP_RDL: state_d = SNAP_RDH;
      SNAP_RDH: state_d = RUN;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    period_d     = period_q;
    cont_d       = cont_q;
    tick_count_d = tick_count_q;
    stop_pend_d  = stop_pend_q;
    stop_seq_d   = stop_seq_q;

    if (state_q == IDLE && start) begin
      period_d     = period;
      cont_d       = continuous;
      tick_count_d = '0;
    end

    if (stop && state_q != IDLE && state_q != RUN && state_q != WR_STOP)
      stop_pend_d = 1'b1;
    // Pending stop is consumed by WR_STOP and never carried across IDLE.
    if (state_d == WR_STOP || state_d == IDLE)
      stop_pend_d = 1'b0;

    if (state_d == WR_STOP)  stop_seq_d = 1'b1;
    if (state_q == CLR_STS)  stop_seq_d = 1'b0;

    if (state_q == CLR_STS && !stop_seq_q)
      tick_count_d = tick_count_q + TICK_W'(1);
  end

`ifdef TIMER_TICK_MASTER_SNAP_EN
  // Read data lags the address by one cycle: low half lands during SNAP_RDH,
  // high half during the following cycle.
  always_comb begin
    snapshot_d   = snapshot_q;
    snap_hi_d    = (state_q == SNAP_RDH);
    snap_valid_d = snap_hi_q;
    if (state_q == SNAP_RDH) snapshot_d[15:0]  = avm_readdata;
    if (snap_hi_q)           snapshot_d[31:16] = avm_readdata;
  end

  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
`endif

  // Outputs decoded from state
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    unique case (state_q)
      WR_PERL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd2; avm_writedata = period_q[15:0];
      end
      WR_PERH: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd3; avm_writedata = period_q[31:16];
      end
      WR_CTRL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd1; avm_writedata = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
      end
      CLR_STS: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
      end
      WR_STOP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd1; avm_writedata = 16'h0009;
      end
`ifdef TIMER_TICK_MASTER_SNAP_EN
      SNAP_WR: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd4;
      end
      SNAP_RDL: begin
        avm_chipselect = 1'b1; avm_address = 3'd4;
      end
      SNAP_RDH: begin
        avm_chipselect = 1'b1; avm_address = 3'd5;
      end
`endif
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign tick       = (state_q == CLR_STS) && !stop_seq_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_timer_tick_master.sv
module tb_timer_tick_master;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, continuous, timer_irq;
  logic [31:0]   period;
  logic [2:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [15:0]   avm_writedata;
  logic [15:0]   avm_readdata = '0;
  logic          busy, tick;
  logic [TW-1:0] tick_count;
`ifdef TIMER_TICK_MASTER_SNAP_EN
  logic          snap_req;
  logic [31:0]   snapshot;
  logic          snap_valid;
`endif

  timer_tick_master #(.TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .period(period), .continuous(continuous), .timer_irq(timer_irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .busy(busy), .tick(tick),
    .tick_count(tick_count)
`ifdef TIMER_TICK_MASTER_SNAP_EN
    , .snap_req(snap_req), .snapshot(snapshot), .snap_valid(snap_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus transfer record: {is_write, address, writedata}
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int tick_seen, idle_viol, snapv_seen;

  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_chipselect) obs_q.push_back({~avm_write_n, avm_address, avm_writedata});
      else if (avm_address != 3'd0 || avm_writedata != 16'd0 || !avm_write_n) idle_viol++;
      if (tick) tick_seen++;
`ifdef TIMER_TICK_MASTER_SNAP_EN
      if (snap_valid) snapv_seen++;
`endif
    end
  end

  // Slave read model: data for a read appears one cycle after its address.
  logic [2:0]  rd_addr = '0;
  logic        rd_v = 1'b0;
  logic [15:0] snap_lo_v = '0, snap_hi_v = '0;
  always @(negedge clk) begin
    rd_v    = avm_chipselect && avm_write_n;
    rd_addr = avm_address;
  end
  always @(posedge clk) begin
    #1;
    if (rd_v && rd_addr == 3'd4)      avm_readdata = snap_lo_v;
    else if (rd_v && rd_addr == 3'd5) avm_readdata = snap_hi_v;
    else                              avm_readdata = 16'($urandom);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void exp_w(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({1'b1, a, d});
  endfunction

  function automatic void exp_r(input logic [2:0] a);
    exp_q.push_back({1'b0, a, 16'h0000});
  endfunction

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete();
    tick_seen = 0; idle_viol = 0; snapv_seen = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin @(negedge clk); k++; end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic compare_bus(input string tag);
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    check({tag, "_nxfer"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check({tag, "_xfer"}, {12'b0, obs_q[i]}, {12'b0, exp_q[i]});
    check({tag, "_idlebus"}, idle_viol, 0);
  endtask

  // stop_mode: 1 stop in RUN, 2 stop+irq together in RUN, 3 stop during WR_PERH,
  // 0 none (non-continuous run ending after its single timeout)
  task automatic run_seq(input string tag, input logic [31:0] p, input logic c,
                         input int n_irq, input int stop_mode);
    int n_done = 0;
    clear_obs();
    exp_w(3'd2, p[15:0]);
    exp_w(3'd3, p[31:16]);
    exp_w(3'd1, {13'b0, 1'b1, c, 1'b1});
    start = 1'b1; period = p; continuous = c;
    cyc(1);
    start = 1'b0; period = $urandom;
    cyc(1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    if (stop_mode == 3) stop = 1'b1;
    else begin start = 1'b1; continuous = ~c; end
    cyc(1);
    stop = 1'b0; start = 1'b0;
    cyc(1 + $urandom_range(0, 3));
    if (stop_mode != 3) begin
      for (int i = 0; i < n_irq; i++) begin
        timer_irq = 1'b1;
        cyc(1);
        timer_irq = 1'b0;
        cyc(1 + $urandom_range(0, 2));
        exp_w(3'd0, 16'h0000);
        n_done++;
        if (!c) break;
      end
    end
    if (stop_mode == 1 || stop_mode == 2 || stop_mode == 3) begin
      if (stop_mode != 3) begin
        stop = 1'b1;
        timer_irq = (stop_mode == 2);
        cyc(1);
        stop = 1'b0; timer_irq = 1'b0;
      end
      exp_w(3'd1, 16'h0009);
      exp_w(3'd0, 16'h0000);
    end
    wait_idle();
    cyc(2);
    compare_bus(tag);
    check({tag, "_ticks"}, tick_seen, n_done);
    check({tag, "_count"}, {29'b0, tick_count}, n_done % (1 << TW));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    timer_irq = 1'b0; period = '0;
`ifdef TIMER_TICK_MASTER_SNAP_EN
    snap_req = 1'b0;
`endif
    cyc(2);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cs", {31'b0, avm_chipselect}, 32'd0);
    check("rst_wn", {31'b0, avm_write_n}, 32'd1);
    check("rst_count", {29'b0, tick_count}, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // stop while idle does nothing
    clear_obs();
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(3);
    check("idle_stop_busy", {31'b0, busy}, 32'd0);
    check("idle_stop_xfer", obs_q.size(), 0);

    run_seq("cont3",   32'h0001_86A0, 1'b1, 3, 1);
    run_seq("oneshot", $urandom, 1'b0, 1, 0);
    run_seq("stopirq", $urandom, 1'b1, 2, 2);
    run_seq("pend",    $urandom, 1'b1, 0, 3);
    run_seq("wrap",    $urandom, 1'b1, 9, 1);

    for (int r = 0; r < 8; r++) begin
      logic c;
      c = 1'($urandom);
      if (c) run_seq("rnd_c", $urandom, 1'b1, $urandom_range(0, 10), $urandom_range(1, 3));
      else   run_seq("rnd_o", $urandom, 1'b0, 1, 0);
    end

`ifdef TIMER_TICK_MASTER_SNAP_EN
    begin
      int k = 0;
      clear_obs();
      snap_lo_v = 16'h1234; snap_hi_v = 16'h0005;
      start = 1'b1; period = 32'h10; continuous = 1'b1;
      cyc(1); start = 1'b0; cyc(4);
      snap_req = 1'b1; cyc(1); snap_req = 1'b0;
      timer_irq = 1'b1;
      while (tick_seen == 0 && k < 20) begin cyc(1); k++; end
      timer_irq = 1'b0;
      check("snap_irq_timeout", {31'b0, (tick_seen == 0)}, 32'd0);
      cyc(3);
      check("snap_data", snapshot, 32'h0005_1234);
      check("snap_valid_cnt", snapv_seen, 1);
      stop = 1'b1; cyc(1); stop = 1'b0;
      wait_idle();
      cyc(2);
      exp_w(3'd2, 16'h0010); exp_w(3'd3, 16'h0000); exp_w(3'd1, 16'h0007);
      exp_w(3'd4, 16'h0000); exp_r(3'd4); exp_r(3'd5);
      exp_w(3'd0, 16'h0000);
      exp_w(3'd1, 16'h0009); exp_w(3'd0, 16'h0000);
      compare_bus("snap");
      check("snap_count", {29'b0, tick_count}, 32'd1);
    end
`endif

    // reset in the middle of a tick service
    begin
      int k = 0;
      clear_obs();
      start = 1'b1; period = $urandom; continuous = 1'b1;
      cyc(1); start = 1'b0; cyc(4);
      timer_irq = 1'b1; cyc(1); timer_irq = 1'b0; cyc(2);
      timer_irq = 1'b1;
      while (!tick && k < 10) begin cyc(1); k++; end
      timer_irq = 1'b0;
      check("mid_tick_seen", {31'b0, tick}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_cs", {31'b0, avm_chipselect}, 32'd0);
      check("mid_rst_addr", {29'b0, avm_address}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_tick", {31'b0, tick}, 32'd0);
      check("mid_rst_count", {29'b0, tick_count}, 32'd0);
      cyc(1);
      reset_n = 1'b1;
      obs_q.delete();
      cyc(4);
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_xfer", obs_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/timer_tick_master.md
TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of tick_count.
REQ-002 SHALL have clk  input  1  rising-edge system clock.
REQ-003 SHALL have reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have start  input  1  one-cycle request to program and start the timer.
REQ-005 SHALL have stop  input  1  one-cycle request to stop the timer.
REQ-006 SHALL have period  input  32  timer load value, sampled on accepted start.
REQ-007 SHALL have continuous  input  1  continuous mode, sampled on accepted start.
REQ-008 SHALL have timer_irq  input  1  interrupt from timer slave.
REQ-009 SHALL have avm_address  output  3  master word address.
REQ-010 SHALL have avm_chipselect  output  1  transfer select.
REQ-011 SHALL have avm_write_n  output  1  active-low write.
REQ-012 SHALL have avm_writedata  output  16  write data.
REQ-013 SHALL have avm_readdata  input  16  read data, valid exactly 1 cycle after address presented.
REQ-014 SHALL have busy  output  1  high whenever FSM is not IDLE.
REQ-015 SHALL have tick  output  1  one-cycle pulse per serviced timeout.
REQ-016 SHALL have tick_count  output  TICK_W  serviced-timeout count.

Function
REQ-017 SHALL use FSM states IDLE, WR_PERL, WR_PERH, WR_CTRL, RUN, CLR_STS, WR_STOP; each write state lasts exactly one cycle, no waitrequest.
REQ-018 SHALL drive idle bus as chipselect=0, write_n=1, address=0, writedata=0 in every non-write, non-read cycle.
REQ-019 SHALL in IDLE on start: capture period/continuous, clear tick_count, go WR_PERL.
REQ-020 SHALL write: WR_PERL addr 2 data period[15:0]; WR_PERH addr 3 data period[31:16]; WR_CTRL addr 1 data {12'b0,0,1,continuous,1} (START=1, CONT, ITO=1); then RUN.
REQ-021 SHALL in RUN with timer_irq=1 go CLR_STS; CLR_STS writes addr 0 data 0, pulses tick the same cycle, increments tick_count modulo 2^TICK_W (wraps to 0).
REQ-022 SHALL after CLR_STS return to RUN if captured continuous=1, else IDLE.
REQ-023 SHALL in RUN on stop (or pending stop) go WR_STOP: write addr 1 data 16'h0009 (STOP=1, ITO=1), then CLR_STS, then IDLE regardless of continuous; this CLR_STS does not pulse tick or increment tick_count.
REQ-024 SHALL give stop priority over timer_irq when both are seen in RUN the same cycle.
REQ-025 SHALL latch stop arriving in WR_PERL/WR_PERH/WR_CTRL/CLR_STS as pending; act on it on first RUN cycle; clear pending on entering WR_STOP.
REQ-026 SHALL ignore start when not IDLE; SHALL ignore stop in IDLE.
REQ-027 SHALL assert busy combinationally from state != IDLE.

Reset
REQ-028 SHALL on reset_n=0 immediately force: state IDLE, busy 0, tick 0, tick_count 0, pending stop 0, bus idle per REQ-018, all captured registers 0.
REQ-029 SHALL abandon any in-progress sequence on reset mid-operation without completing bus writes.

Configuration
REQ-030 SHALL support macro TIMER_TICK_MASTER_SNAP_EN.
REQ-031 With macro: add input snap_req (1), outputs snapshot (32) and snap_valid (1); states SNAP_WR, SNAP_RDL, SNAP_RDH; in RUN with snap_req and no stop/irq: SNAP_WR writes addr 4 data 0, SNAP_RDL presents addr 4 read (chipselect=1, write_n=1), SNAP_RDH presents addr 5 and captures avm_readdata into snapshot[15:0], next cycle captures snapshot[31:16], pulses snap_valid for 1 cycle, returns RUN; snap_req ignored outside RUN; irq arriving during snapshot serviced on return to RUN.
REQ-032 Without macro: no snap ports, no snapshot states, addresses 4/5 never driven.

Verification
REQ-033 Start with period=32'h0001_86A0, continuous=1 -> writes (2,86A0),(3,0001),(1,0007) on three consecutive cycles, busy=1.
REQ-034 In RUN, timer_irq for 3 separate events -> three (0,0000) writes, three tick pulses, tick_count=3, stays RUN.
REQ-035 continuous=0, one irq -> write (1,0005) at start, one (0,0000) write, tick_count=1, IDLE, busy=0.
REQ-036 stop and timer_irq same cycle in RUN -> (1,0009) then (0,0000), tick_count unchanged, IDLE.
REQ-037 stop during WR_PERH -> WR_CTRL completes, first RUN cycle followed by (1,0009),(0,0000), IDLE.
REQ-038 With SNAP_EN, readdata 16'h1234 then 16'h0005 on reads -> snapshot=32'h0005_1234, snap_valid one cycle; reset_n low mid-sequence -> bus idle, tick_count=0 next cycle.
